// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the frame-granular stream round-robin arbiter.
package stream_arb_pkg;

  // Width of one forwarded stream element.
  localparam int BYTE_W = 8;

  // Arbiter control states: arbitrate, forward one frame, hold the bus idle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Modulo-n increment used to advance the round-robin pointer past a winner.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit at or after base,
// wrapping modulo N. found is low when no request is set (idx is then 0).
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] idx
);

  logic         hit;
  int unsigned  cand;
  logic [W-1:0] pos;

  // Walk the requests in priority order starting at base; the first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    pos  = '0;
    for (int off = 0; off < N; off++) begin
      cand = (32'(base) + off) % N;
      pos  = W'(cand);
      if (!hit && req[pos]) begin
        idx = pos;
        hit = 1'b1;
      end
    end
  end

  assign found = |req;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Frame-granular round-robin arbiter sharing one byte-stream ingress (rxd/rx_dv)
// between NUM_SRC requesters. One source owns the bus for a whole frame; a frame
// ends on src_last or after MAX_LEN bytes, after which IFG idle cycles are forced.
//
// Optional feature: define ARB_STATS_EN to add frame_cnt, a per-source
// saturating 16-bit count of completed frames (src_last or truncation).
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IFG     = 2,
  parameter int MAX_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*BYTE_W-1:0]    src_data,
  input  logic [NUM_SRC-1:0]           src_last,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [BYTE_W-1:0]            rxd,
  output logic                         rx_dv,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         trunc_err
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]        frame_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // len_cnt value at which the next accepted byte is the MAX_LEN-th of the frame.
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
  // gap_cnt value on the final GAP cycle; unused when IFG is zero.
  localparam logic [3:0]       GAP_LAST = 4'((IFG == 0) ? 0 : IFG - 1);
  // Where a finished frame goes: skip GAP entirely when no gap is configured.
  localparam state_t           END_STATE = (IFG > 0) ? GAP : IDLE;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]   len_cnt;
  logic [3:0]         gap_cnt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               beat;
  logic               at_max;
  logic               frame_end;

  rr_picker #(
    .N (NUM_SRC),
    .W (IDX_W)
  ) u_picker (
    .req   (src_valid),
    .base  (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Ready decodes the registered grant, so only the owner of the frame is ready
  // and reset drops it in the same cycle.
  always_comb begin
    src_ready = '0;
    if (state == XFER) begin
      src_ready[grant_id] = 1'b1;
    end
  end

  assign beat      = (state == XFER) && src_valid[grant_id];
  assign at_max    = (len_cnt == LEN_LAST);
  assign frame_end = beat && (src_last[grant_id] || at_max);

  // Arbitration/transfer/gap sequencer with all stream outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      len_cnt   <= '0;
      gap_cnt   <= '0;
      grant_id  <= '0;
      rxd       <= '0;
      rx_dv     <= 1'b0;
      busy      <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge value of state, len_cnt and grant_id regardless of ordering.
      rx_dv     <= 1'b0;
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= XFER;
            busy     <= 1'b1;
          end
        end
        XFER: begin
          if (beat) begin
            rxd   <= src_data[grant_id*BYTE_W +: BYTE_W];
            rx_dv <= 1'b1;
            if (frame_end) begin
              rr_ptr    <= IDX_W'(next_idx(32'(grant_id), NUM_SRC));
              len_cnt   <= '0;
              gap_cnt   <= '0;
              // A cut without src_last leaves the source mid-frame; flag it.
              trunc_err <= !src_last[grant_id];
              state     <= END_STATE;
              busy      <= (IFG > 0);
            end else begin
              len_cnt <= len_cnt + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Per-source completed-frame counters; saturate rather than wrap so a
  // long-running source never appears to have sent few frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_end && (frame_cnt[grant_id*16 +: 16] != 16'hFFFF)) begin
      frame_cnt[grant_id*16 +: 16] <= frame_cnt[grant_id*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single byte-stream ingress (rxd/rx_dv) of the data wrapper between NUM_SRC requesters.
- Grants one source per frame and forwards its bytes with registered outputs.
- Enforces a minimum inter-frame gap and a maximum frame length.
- Sits directly upstream of the wrapper; its rxd/rx_dv drive the wrapper's rxd/rx_dv.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- IFG, 2, idle cycles forced on rx_dv between frames (0..15).
- MAX_LEN, 64, maximum bytes per frame before forced release (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  NUM_SRC*8  per-source byte; source i at bits [8i+7:8i].
- src_last  in  NUM_SRC  marks final byte of a frame.
- src_ready  out  NUM_SRC  per-source accept; one-hot or zero.
- rxd  out  8  forwarded byte to wrapper.
- rx_dv  out  1  forwarded byte valid.
- grant_id  out  $clog2(NUM_SRC)  currently/last granted source.
- busy  out  1  high in XFER or GAP.
- trunc_err  out  1  one-cycle pulse when a frame is cut at MAX_LEN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: rxd=0, rx_dv=0, src_ready=0, grant_id=0, busy=0, trunc_err=0, rr_ptr=0, state=IDLE, len_cnt=0, gap_cnt=0.
- Reset mid-frame aborts the frame immediately. No partial byte is emitted after reset release.
- States:
  - IDLE: if any src_valid, pick the first valid index starting at rr_ptr, wrapping modulo NUM_SRC. Register grant_id, then go to XFER. No valid: stay in IDLE.
  - XFER: src_ready[grant_id]=1 (combinational from state and grant_id); all other ready bits 0.
    - Beat = src_valid[g] & src_ready[g].
    - Each beat: rxd<=src_data[g], rx_dv<=1, len_cnt++.
    - No beat: rx_dv<=0 (bubble allowed); grant is held.
  - End of frame: a beat with src_last, or the beat where len_cnt reaches MAX_LEN.
    - Set rr_ptr<=(g+1) mod NUM_SRC and len_cnt<=0.
    - Go to GAP if IFG>0, else IDLE.
    - MAX_LEN cut without src_last: trunc_err pulses in the cycle after that beat. The source's remaining bytes are treated as a new frame when it is next granted.
  - GAP: rx_dv=0, src_ready=0, gap_cnt counts IFG cycles, then go to IDLE.
- Latency:
  - src_valid rising in IDLE at cycle t gives grant/ready at t+1.
  - First beat accepted at t+1; rx_dv=1 at t+2.
  - Each subsequent beat appears on rx_dv one cycle after acceptance.
- rx_dv idle gap between frames = IFG + 1 cycles minimum (GAP cycles plus one IDLE arbitration cycle).
- Single-byte frame (src_last on first beat) is legal.
- MAX_LEN=1 means every beat ends a frame.
- A source deasserting valid mid-frame keeps the grant indefinitely. There is no timeout.
- busy=1 in XFER and GAP, 0 in IDLE.
- len_cnt width is $clog2(MAX_LEN+1). Wrap is impossible because the counter clears at MAX_LEN.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds output frame_cnt (NUM_SRC*16). This is a per-source saturating count of completed frames (src_last or truncation), cleared by rst, and saturating at 16'hFFFF.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package stream_arb_pkg:
  - state enum {IDLE, XFER, GAP};
  - BYTE_W=8;
  - function next_idx(idx, n) for modulo increment.
- Sub-module rr_picker: combinational; inputs req vector and base pointer; outputs found and idx (first set bit at or after base, wrapping).

Test Plan:
- Reset: assert rst mid-XFER with src_valid=1 → same cycle rx_dv=0, src_ready=0; after release, IDLE and rr_ptr=0.
- Single source: src0 sends 3 bytes 8'hA1,8'hA2,8'hA3 (last on A3), IFG=2 → rx_dv high 3 consecutive cycles starting 2 cycles after first valid, with rxd A1,A2,A3; then rx_dv low ≥3 cycles.
- Round-robin: all 4 sources continuously valid with 1-byte frames → grant_id sequence 0,1,2,3,0.
- Fairness with a skip: sources 1 and 3 valid, rr_ptr=2 → source 3 granted first, then source 1.
- Truncation: MAX_LEN=4, src2 sends 6 bytes with last on the 6th → 4 bytes forwarded, trunc_err pulses once; after the gap, src2's remaining 2 bytes are forwarded as a new frame.
- Bubble: granted source drops valid for 3 cycles mid-frame → rx_dv low 3 cycles, grant_id unchanged, other sources' src_ready stay 0.
